// File: rtl/tamagotchi_pkg.sv
// Shared types and constants for the tamagotchi input conditioning stage.
// Default cycle counts assume a 50 MHz clk.
package tamagotchi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } btn_state_t;

  localparam logic [1:0] SEL_SALUD     = 2'd0;
  localparam logic [1:0] SEL_ENERGIA   = 2'd1;
  localparam logic [1:0] SEL_HAMBRE    = 2'd2;
  localparam logic [1:0] SEL_DIVERSION = 2'd3;

  localparam int DEF_DEBOUNCE_CYCLES   = 500_000;      // 10 ms
  localparam int DEF_LONG_PRESS_CYCLES = 100_000_000;  // 2 s
  localparam int DEF_SYNC_STAGES       = 2;

  // Counter width for a count of n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tamagotchi_input_cond_sync_debounce.sv
// Synchronizer chain followed by a stable-value debouncer, with registered
// one-cycle rise/fall pulses that coincide with the new stable value.
module sync_debounce
  import tamagotchi_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit IDLE_VALUE      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   stable_reg;
  logic                   rise_reg;
  logic                   fall_reg;
  logic                   synced;

  assign synced = sync_reg[SYNC_STAGES-1];

  // Plain shift chain: nothing between the stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg <= {SYNC_STAGES{IDLE_VALUE}};
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable_reg <= IDLE_VALUE;
      cnt_reg    <= '0;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      if (synced == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        stable_reg <= synced;
        cnt_reg    <= '0;
        rise_reg   <= synced;
        fall_reg   <= ~synced;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign stable = stable_reg;
  assign rise   = rise_reg;
  assign fall   = fall_reg;

endmodule

// File: rtl/tamagotchi_input_cond.sv
// Conditions the light sensor and the TEST/SEL buttons for the tamagotchi FSM:
// debounced light level with edge pulses, TEST long-press toggle, SEL index.
module tamagotchi_input_cond
  import tamagotchi_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int SYNC_STAGES       = DEF_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       light_raw,
  input  logic       btn_test_n,
  input  logic       btn_sel_n,
  output logic       ledsign,
  output logic       light_rise,
  output logic       light_fall,
  output logic       test_mode,
  output logic [1:0] sel,
  output logic       sel_pulse
);

  localparam int BTN_TEST = 0;
  localparam int BTN_SEL  = 1;
  localparam int HOLD_W   = cnt_width(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_rise;
  logic [1:0] btn_fall;
  logic [1:0] short_evt;
  logic [1:0] long_evt;
  logic       unused_btn;

  logic       test_mode_reg;
  logic [1:0] sel_reg;
  logic       sel_pulse_reg;

  assign btn_raw = {btn_sel_n, btn_test_n};

  sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .IDLE_VALUE     (1'b0)
  ) u_light (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (light_raw),
    .stable(ledsign),
    .rise  (light_rise),
    .fall  (light_fall)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      btn_state_t        state_reg;
      logic [HOLD_W-1:0] hold_reg;
      logic              short_reg;
      logic              long_reg;

      sync_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .IDLE_VALUE     (1'b1)
      ) u_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (btn_raw[gi]),
        .stable(btn_level[gi]),
        .rise  (btn_rise[gi]),
        .fall  (btn_fall[gi])
      );

      // Buttons are active-low: a debounced level of 1 means released.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_reg <= IDLE;
          hold_reg  <= '0;
          short_reg <= 1'b0;
          long_reg  <= 1'b0;
        end else begin
          short_reg <= 1'b0;
          long_reg  <= 1'b0;
          case (state_reg)
            IDLE: begin
              if (!btn_level[gi]) begin
                state_reg <= PRESSED;
                hold_reg  <= '0;
              end
            end
            PRESSED: begin
              if (btn_level[gi]) begin
                short_reg <= 1'b1;
                state_reg <= IDLE;
              end else if (hold_reg == HOLD_LAST) begin
                long_reg  <= 1'b1;
                state_reg <= HELD;
              end else if (hold_reg != {HOLD_W{1'b1}}) begin
                hold_reg <= hold_reg + 1'b1;
              end
            end
            HELD: begin
              if (btn_level[gi]) begin
                state_reg <= IDLE;
              end
            end
            default: state_reg <= IDLE;
          endcase
        end
      end

      assign short_evt[gi] = short_reg;
      assign long_evt[gi]  = long_reg;
    end
  endgenerate

  // Button edge pulses and the TEST short press carry no action here.
  assign unused_btn = ^{btn_rise, btn_fall, short_evt[BTN_TEST]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      test_mode_reg <= 1'b0;
      sel_reg       <= SEL_SALUD;
      sel_pulse_reg <= 1'b0;
    end else begin
      test_mode_reg <= test_mode_reg ^ long_evt[BTN_TEST];
      sel_pulse_reg <= long_evt[BTN_SEL] | short_evt[BTN_SEL];
      if (long_evt[BTN_SEL]) begin
        sel_reg <= SEL_SALUD;
      end else if (short_evt[BTN_SEL]) begin
        sel_reg <= sel_reg + 2'd1;
      end
    end
  end

  assign test_mode = test_mode_reg;
  assign sel       = sel_reg;
  assign sel_pulse = sel_pulse_reg;

endmodule
